// File: rtl/rv_skid_buf.sv
// Two-entry valid/ready skid buffer between rv32i pipeline stages.
// Outputs decode registered state only, so no ready/valid combinational path crosses it.
module rv_skid_buf #(
    parameter int                   BW_DATA  = 32,
    parameter logic [BW_DATA-1:0]   INIT_VAL = '0
) (
    input  logic               i_skid_clk,
    input  logic               i_skid_rstn,
    input  logic               i_skid_flush,
    input  logic               i_skid_valid,
    output logic               o_skid_ready,
    input  logic [BW_DATA-1:0] i_skid_data,
    output logic               o_skid_valid,
    input  logic               i_skid_ready,
    output logic [BW_DATA-1:0] o_skid_data,
    output logic [1:0]         o_skid_level
);

    // Handshake: an entry moves on a rising edge where valid and ready are both
    // high; valid never drops and data never changes until that happens (or a flush).
    // State encoding equals the occupancy, so o_skid_level doubles as the state view.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state;
    logic [BW_DATA-1:0] main_q;
    logic [BW_DATA-1:0] skid_q;
    logic               in_fire;
    logic               out_fire;

    assign o_skid_valid = (state != ST_EMPTY);
    assign o_skid_ready = (state != ST_FULL);
    assign o_skid_level = state;
    assign o_skid_data  = main_q;

    assign in_fire  = i_skid_valid & o_skid_ready;
    assign out_fire = o_skid_valid & i_skid_ready;

    always_ff @(posedge i_skid_clk or negedge i_skid_rstn) begin
        if (!i_skid_rstn) begin
            state  <= ST_EMPTY;
            main_q <= INIT_VAL;
            skid_q <= INIT_VAL;
        end else if (i_skid_flush) begin
            // Held entries are dropped; data registers keep stale, now-invalid contents.
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_BUSY;
                        main_q <= i_skid_data;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && !out_fire) begin
                        state  <= ST_FULL;
                        skid_q <= i_skid_data;
                    end else if (!in_fire && out_fire) begin
                        state <= ST_EMPTY;
                    end else if (in_fire && out_fire) begin
                        main_q <= i_skid_data;
                    end
                end
                ST_FULL: begin
                    // Ready is low here, so only the older entry can leave.
                    if (out_fire) begin
                        state  <= ST_BUSY;
                        main_q <= skid_q;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_skid_buf.sv
// Bench for rv_skid_buf: directed sequences plus a randomized run, with a
// negedge scoreboard that tracks every accepted entry against the output stream.
module tb_rv_skid_buf;

    localparam int W = 32;

    logic         clk;
    logic         rstn;
    logic         flush;
    logic         us_valid;
    logic         us_ready;
    logic [W-1:0] us_data;
    logic         ds_valid;
    logic         ds_ready;
    logic [W-1:0] ds_data;
    logic [1:0]   level;

    logic [W-1:0] exp_q[$];
    int           n_tests;
    int           n_fail;

    rv_skid_buf #(.BW_DATA(W), .INIT_VAL('0)) dut (
        .i_skid_clk  (clk),
        .i_skid_rstn (rstn),
        .i_skid_flush(flush),
        .i_skid_valid(us_valid),
        .o_skid_ready(us_ready),
        .i_skid_data (us_data),
        .o_skid_valid(ds_valid),
        .i_skid_ready(ds_ready),
        .o_skid_data (ds_data),
        .o_skid_level(level)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [1:0] lvl, input logic [W-1:0] data);
        chk({name, "_level"}, W'(level), W'(lvl));
        chk({name, "_valid"}, W'(ds_valid), W'(lvl != 2'd0));
        chk({name, "_ready"}, W'(us_ready), W'(lvl != 2'd2));
        if (lvl != 2'd0) chk({name, "_data"}, ds_data, data);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
        end else begin
            chk("occupancy", W'(level), W'(exp_q.size()));
            chk("valid_vs_occ", W'(ds_valid), W'(exp_q.size() != 0));
            chk("ready_vs_occ", W'(us_ready), W'(exp_q.size() < 2));
            if (ds_valid && ds_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("[TB] FAIL underflow: got 0x%0h expected no output at %0t", ds_data, $time);
                end else begin
                    chk("out_data", ds_data, exp_q.pop_front());
                end
            end
            if (flush) exp_q.delete();
            else if (us_valid && us_ready) exp_q.push_back(us_data);
        end
    end

    // ---------------- stimulus ----------------
    int sent;
    int cyc;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rstn     = 1'b1;
        flush    = 1'b0;
        us_valid = 1'b0;
        us_data  = '0;
        ds_ready = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk_state("reset", 2'd0, '0);
        chk("reset_data", ds_data, '0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk_state("idle", 2'd0, '0);

        // Streaming: one entry per cycle, level stays 1
        ds_ready = 1'b1;
        us_valid = 1'b1;
        us_data  = 32'h11;
        tick();
        chk_state("stream0", 2'd1, 32'h11);
        us_data = 32'h22;
        tick();
        chk_state("stream1", 2'd1, 32'h22);
        us_data = 32'h33;
        tick();
        chk_state("stream2", 2'd1, 32'h33);
        us_valid = 1'b0;
        tick();
        chk_state("stream_drain", 2'd0, '0);

        // Backpressure and stall stability
        ds_ready = 1'b0;
        us_valid = 1'b1;
        us_data  = 32'hA1;
        tick();
        chk_state("bp0", 2'd1, 32'hA1);
        us_data = 32'hA2;
        tick();
        chk_state("bp_full", 2'd2, 32'hA1);
        us_data = 32'hA3;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state("stall", 2'd2, 32'hA1);
        end
        ds_ready = 1'b1;
        tick();
        chk_state("bp_rel0", 2'd1, 32'hA2);
        tick();
        chk_state("bp_rel1", 2'd1, 32'hA3);
        us_valid = 1'b0;
        tick();
        chk_state("bp_drain", 2'd0, '0);

        // Flush while FULL with 0xFF offered upstream
        ds_ready = 1'b0;
        us_valid = 1'b1;
        us_data  = 32'hB1;
        tick();
        us_data = 32'hB2;
        tick();
        chk_state("fl_full", 2'd2, 32'hB1);
        flush   = 1'b1;
        us_data = 32'hFF;
        tick();
        chk_state("fl_full_after", 2'd0, '0);
        flush    = 1'b0;
        us_valid = 1'b0;
        ds_ready = 1'b1;
        tick();
        tick();
        chk("fl_full_quiet", W'(ds_valid), W'(1'b0));

        // Flush while BUSY: the in_fire of 0xFF in the flush cycle is discarded
        ds_ready = 1'b0;
        us_valid = 1'b1;
        us_data  = 32'hC1;
        tick();
        chk_state("fl_busy", 2'd1, 32'hC1);
        flush   = 1'b1;
        us_data = 32'hFF;
        tick();
        chk_state("fl_busy_after", 2'd0, '0);
        flush    = 1'b0;
        us_valid = 1'b0;
        ds_ready = 1'b1;
        tick();
        tick();
        chk("fl_busy_quiet", W'(ds_valid), W'(1'b0));

        // Flush with a simultaneous out_fire: D1 still counts as delivered
        us_valid = 1'b1;
        us_data  = 32'hD1;
        tick();
        chk_state("fl_out", 2'd1, 32'hD1);
        us_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        chk_state("fl_out_after", 2'd0, '0);

        // Random traffic, 50% valid / 50% ready
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            us_valid = 1'($urandom_range(0, 1));
            ds_ready = 1'($urandom_range(0, 1));
            us_data  = $urandom;
            @(negedge clk);
            if (us_valid && us_ready) sent++;
            tick();
            cyc++;
        end
        if (sent < 1000) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL rand_budget: got %0d entries expected 1000", sent);
        end
        us_valid = 1'b0;
        ds_ready = 1'b1;
        cyc = 0;
        while (level != 2'd0 && cyc < 10) begin
            tick();
            cyc++;
        end
        chk("rand_drain_level", W'(level), '0);
        chk("rand_drain_queue", W'(exp_q.size()), '0);

        // Asynchronous reset mid-cycle while FULL
        ds_ready = 1'b0;
        us_valid = 1'b1;
        us_data  = 32'hE1;
        tick();
        us_data = 32'hE2;
        tick();
        chk_state("rst_full", 2'd2, 32'hE1);
        us_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk_state("rst_async", 2'd0, '0);
        chk("rst_async_data", ds_data, '0);
        tick();
        rstn = 1'b1;
        tick();
        chk_state("rst_release", 2'd0, '0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
